// File: rtl/rr_mux_pkg.sv
// ---------------------------------------------------------------------------
// rr_mux_pkg: shared state encoding and channel-index width helper.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rr_mux_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Channel index is at least one bit so a single-channel build still has a port.
  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter: combinational rotate-priority pick starting after last_grant. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int  NUM_CH = 4,
  localparam int CH_W   = ch_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last_grant,
  output logic [CH_W-1:0]   grant,
  output logic              any_req
);

  logic            upper_hit;
  logic [CH_W-1:0] upper_idx;
  logic [CH_W-1:0] lower_idx;

  // Scan downward so the lowest index in each half wins; the half above
  // last_grant has priority, otherwise wrap to the lowest requester.
  always_comb begin
    upper_hit = 1'b0;
    upper_idx = '0;
    lower_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (CH_W'(i) > last_grant) begin
          upper_hit = 1'b1;
          upper_idx = CH_W'(i);
        end else begin
          lower_idx = CH_W'(i);
        end
      end
    end
  end

  assign grant   = upper_hit ? upper_idx : lower_idx;
  assign any_req = |req;

endmodule

`default_nettype wire

// File: rtl/rr_stream_mux.sv
// ---------------------------------------------------------------------------
// rr_stream_mux: packet-locked round-robin N:1 valid/ready stream mux.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_stream_mux
  import rr_mux_pkg::*;
#(
  parameter int  NUM_CH = 4,
  parameter int  DATA_W = 8,
  localparam int CH_W   = ch_width(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_last,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [CH_W-1:0]          out_ch,
  input  logic                     out_ready,
  output logic                     busy
);

  state_t          state;
  logic [CH_W-1:0] grant;
  logic [CH_W-1:0] last_grant;
  logic [CH_W-1:0] arb_grant;
  logic            arb_any;
  logic            xfer;
  logic [DATA_W-1:0] ch_data [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign ch_data[g] = in_data[g*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .NUM_CH(NUM_CH)
  ) u_arb (
    .req       (in_valid),
    .last_grant(last_grant),
    .grant     (arb_grant),
    .any_req   (arb_any)
  );

  always_comb begin
    in_ready = '0;
    if (state == LOCKED) begin
      in_ready[grant] = ~out_valid | out_ready;
    end
  end

  assign xfer = (state == LOCKED) & in_valid[grant] & in_ready[grant];
  assign busy = (state == LOCKED) | out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_ch     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            grant <= arb_grant;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          // The lock is held until the end-of-packet beat is accepted.
          if (xfer && in_last[grant]) begin
            state      <= IDLE;
            last_grant <= grant;
          end
        end
        default: state <= IDLE;
      endcase

      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= ch_data[grant];
        out_last  <= in_last[grant];
        out_ch    <= grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rr_stream_mux.sv
// ---------------------------------------------------------------------------
// tb_rr_stream_mux: directed self-checking bench for rr_stream_mux.    Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rr_stream_mux;

  logic        clk;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic [1:0]  out_ch;
  logic        out_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  rr_stream_mux #(
    .NUM_CH(4),
    .DATA_W(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_ch   (out_ch),
    .out_ready(out_ready),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ch, input logic v, input logic [7:0] d, input logic l);
    in_valid[ch]       = v;
    in_data[ch*8 +: 8] = d;
    in_last[ch]        = l;
  endtask

  task automatic chk_beat(input string tag, input logic [7:0] d, input logic [1:0] ch, input logic l);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"},  32'(out_data),  32'(d));
    chk({tag, "_ch"},    32'(out_ch),    32'(ch));
    chk({tag, "_last"},  32'(out_last),  32'(l));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    in_last   = '0;
    out_ready = 1'b1;

    // Reset held with every channel requesting
    in_valid = 4'hF;
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_last",  32'(out_last),  32'd0);
    chk("rst_out_ch",    32'(out_ch),    32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    in_valid = '0;
    rst      = 1'b0;
    step();

    // Single channel, 3-beat packet on ch2
    drive(2, 1'b1, 8'hA1, 1'b0);
    #1;
    chk("sc_idle_ready", 32'(in_ready), 32'd0);
    step();
    chk("sc_lock_ready", 32'(in_ready), 32'h4);
    chk("sc_lock_noout", 32'(out_valid), 32'd0);
    chk("sc_lock_busy",  32'(busy), 32'd1);
    step();
    chk_beat("sc_b1", 8'hA1, 2'd2, 1'b0);
    drive(2, 1'b1, 8'hA2, 1'b0);
    step();
    chk_beat("sc_b2", 8'hA2, 2'd2, 1'b0);
    drive(2, 1'b1, 8'hA3, 1'b1);
    step();
    chk_beat("sc_b3", 8'hA3, 2'd2, 1'b1);
    drive(2, 1'b0, 8'h00, 1'b0);
    step();
    chk("sc_drain_valid", 32'(out_valid), 32'd0);
    chk("sc_drain_busy",  32'(busy), 32'd0);

    // Round robin from a fresh reset: all channels send 1-beat packets
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) drive(c, 1'b1, 8'(8'h10 + c), 1'b1);
    step();
    chk("rr_arb_noout", 32'(out_valid), 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk_beat($sformatf("rr_k%0d", k), 8'(8'h10 + (k % 4)), 2'(k % 4), 1'b1);
      if (k == 4) in_valid = '0;
      step();
      chk($sformatf("rr_bubble%0d", k), 32'(out_valid), 32'd0);
    end

    // Backpressure on ch1 (last_grant is now 0)
    drive(1, 1'b1, 8'hB1, 1'b0);
    step();
    chk("bp_lock_ready", 32'(in_ready), 32'h2);
    step();
    chk_beat("bp_b1", 8'hB1, 2'd1, 1'b0);
    drive(1, 1'b1, 8'hB2, 1'b0);
    out_ready = 1'b0;
    #1;
    chk("bp_stall_ready", 32'(in_ready), 32'h0);
    step();
    chk_beat("bp_hold1", 8'hB1, 2'd1, 1'b0);
    step();
    chk_beat("bp_hold2", 8'hB1, 2'd1, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("bp_resume_ready", 32'(in_ready), 32'h2);
    step();
    chk_beat("bp_b2", 8'hB2, 2'd1, 1'b0);
    drive(1, 1'b1, 8'hB3, 1'b0);
    out_ready = 1'b0;
    step();
    chk_beat("bp_hold3", 8'hB2, 2'd1, 1'b0);
    out_ready = 1'b1;
    step();
    chk_beat("bp_b3", 8'hB3, 2'd1, 1'b0);
    drive(1, 1'b1, 8'hB4, 1'b1);
    step();
    chk_beat("bp_b4", 8'hB4, 2'd1, 1'b1);
    drive(1, 1'b0, 8'h00, 1'b0);
    out_ready = 1'b0;
    step();
    chk_beat("bp_hold4", 8'hB4, 2'd1, 1'b1);
    chk("bp_busy_outreg", 32'(busy), 32'd1);
    out_ready = 1'b1;
    step();
    chk("bp_drain_valid", 32'(out_valid), 32'd0);
    chk("bp_drain_busy",  32'(busy), 32'd0);

    // Lock: ch0 stalls mid-packet while ch3 requests (last_grant is now 1)
    drive(0, 1'b1, 8'hC1, 1'b0);
    step();
    drive(3, 1'b1, 8'h33, 1'b1);
    chk("lk_ready_ch0", 32'(in_ready), 32'h1);
    step();
    chk_beat("lk_c1", 8'hC1, 2'd0, 1'b0);
    drive(0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("lk_gap%0d_valid", k), 32'(out_valid), 32'd0);
      chk($sformatf("lk_gap%0d_ready", k), 32'(in_ready), 32'h1);
    end
    drive(0, 1'b1, 8'hC2, 1'b1);
    step();
    chk_beat("lk_c2", 8'hC2, 2'd0, 1'b1);
    drive(0, 1'b0, 8'h00, 1'b0);
    step();
    chk("lk_arb_noout", 32'(out_valid), 32'd0);
    chk("lk_ready_ch3", 32'(in_ready), 32'h8);
    step();
    chk_beat("lk_ch3", 8'h33, 2'd3, 1'b1);
    drive(3, 1'b0, 8'h00, 1'b0);
    step();

    // Wrap priority: last_grant=3, requests on ch0 and ch2
    drive(0, 1'b1, 8'hD0, 1'b1);
    drive(2, 1'b1, 8'hD2, 1'b1);
    step();
    step();
    chk_beat("wr_first", 8'hD0, 2'd0, 1'b1);
    drive(0, 1'b0, 8'h00, 1'b0);
    step();
    step();
    chk_beat("wr_second", 8'hD2, 2'd2, 1'b1);
    drive(2, 1'b0, 8'h00, 1'b0);
    step();

    // Asynchronous reset mid-packet (last_grant is now 2, ch1 wins)
    drive(1, 1'b1, 8'hE1, 1'b0);
    step();
    step();
    chk_beat("ar_e1", 8'hE1, 2'd1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_out_data",  32'(out_data),  32'd0);
    chk("ar_in_ready",  32'(in_ready),  32'd0);
    chk("ar_busy",      32'(busy),      32'd0);
    drive(1, 1'b0, 8'h00, 1'b0);
    step();
    rst = 1'b0;
    step();
    chk("ar_post_valid", 32'(out_valid), 32'd0);
    chk("ar_post_busy",  32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
Parametrised N-to-1 streaming multiplexer, the successor to the 2x1 mux. It is generalised from two single-bit inputs to NUM_CH channels of DATA_W bits with valid/ready handshake.
- Replaces the static select with packet-locked round-robin arbitration.
- Output is a single register stage.
- Sits between multiple packet producers and one shared downstream consumer.

Parameters:
NUM_CH, 4, number of input channels (>=1)
DATA_W, 8, data width per channel
CH_W, max(1,$clog2(NUM_CH)), derived localparam, width of channel index

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  NUM_CH  per-channel beat valid
in_data  input  NUM_CH*DATA_W  flattened data, channel i at [i*DATA_W +: DATA_W]
in_last  input  NUM_CH  per-channel end-of-packet flag
in_ready  output  NUM_CH  per-channel ready, at most one bit high
out_valid  output  1  output beat valid
out_data  output  DATA_W  output beat data
out_last  output  1  output end-of-packet
out_ch  output  CH_W  source channel of current output beat
out_ready  input  1  downstream ready
busy  output  1  packet in progress or output register occupied

Behaviour:
- Reset (asynchronous assert, any time): out_valid=0, out_data=0, out_last=0, out_ch=0, in_ready=0, busy=0, state=IDLE, grant=0, last_grant=NUM_CH-1 so channel 0 has first priority. A partial packet is discarded. Mid-packet reset returns to IDLE with no further beats.
- States: IDLE, LOCKED.
- IDLE:
  - in_ready all 0.
  - If any in_valid is high, grant is the first requesting channel scanning from (last_grant+1) mod NUM_CH upward with wrap. At the next edge grant is registered and state goes to LOCKED.
  - If no in_valid is high, state stays IDLE.
- LOCKED:
  - in_ready[grant] = ~out_valid | out_ready. All other in_ready bits are 0.
  - Transfer occurs when in_valid[grant] & in_ready[grant]. At that edge: out_data=in_data[grant], out_last=in_last[grant], out_ch=grant, out_valid=1.
  - If the transferred beat has in_last=1: state goes to IDLE and last_grant=grant.
  - If in_valid[grant] drops mid-packet, state stays LOCKED and the block waits. There is no timeout and no switching to another channel.
- Output register:
  - If out_valid & out_ready and no new transfer occurs in that cycle, out_valid becomes 0.
  - While out_valid & ~out_ready, out_data, out_last and out_ch hold stable.
- Latency: in_valid asserted in IDLE at cycle 0 gives in_ready high in cycle 1, and out_valid appears after the edge ending cycle 1.
- Throughput: 1 beat/cycle within a packet, with one arbitration bubble cycle between packets.
- Single-beat packets (in_valid & in_last on the first beat) are legal: lock and release complete within one LOCKED cycle.
- Requests from non-granted channels never affect the outputs. Any channel requesting continuously is served within NUM_CH packets.
- busy = (state==LOCKED) | out_valid.
- NUM_CH=1 degenerates to a registered pass-through with a bubble between packets. out_ch is always 0.

Decomposition:
- Package rr_mux_pkg: state enum typedef (IDLE, LOCKED) and a helper function for the CH_W computation.
- Sub-module rr_arbiter: combinational, NUM_CH-bit req plus CH_W-bit last_grant in, CH_W-bit grant and any_req out. Rotate-priority pick, reusable elsewhere.
- The top level holds the FSM, grant/last_grant registers and the output register.

Test Plan:
- Reset: hold rst=1, drive all in_valid=1 → all outputs 0, in_ready=0. Assert rst asynchronously mid-packet → outputs clear immediately without a clock edge.
- Single channel: ch2 sends a 3-beat packet (0xA1, 0xA2, 0xA3 with last), out_ready=1 → out_data A1/A2/A3 on consecutive cycles, out_ch=2, out_last only on A3, first out_valid 2 cycles after in_valid.
- Round-robin: all 4 channels continuously send 1-beat packets (data=0x10+ch) → out_ch sequence 0,1,2,3,0, with one idle cycle between beats.
- Backpressure: ch1 sends 4 beats while out_ready toggles 1,0,0,1,... → out_data holds during stalls, in_ready[1]=0 while out_valid & ~out_ready, no beat lost or duplicated.
- Lock: ch0 mid-packet drops in_valid for 3 cycles while ch3 requests → no ch3 beat appears until ch0 delivers its last beat, then ch3 is granted next.
- Wrap priority: last_grant=3, requests on ch0 and ch2 → ch0 granted first, then ch2.
